vga_pll_sequencer: RTL and testbench

- Sequences the VGA pixel-clock PLL in the 48 MHz input domain.
- Pulses the PLL reset and waits for a stable lock, retrying on timeout.
- Gates the video reset until lock is stable, and restarts the PLL on loss of lock or a software request.
- Sits between the board reset/clock and the PLL instance; its outputs feed the video timing generator and CSR status.

---
 rtl/vga_pll_sequencer_if.sv | 40 ++++
 rtl/vga_pll_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vga_pll_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pll_sequencer_if.sv
// -----------------------------------------------------------------------------
// vga_pll_sequencer_if
//   Groups the sequencer's PLL-side and status-side signals into one bundle.
//
//   master : the sequencer (samples pll_locked/restart_req, drives everything else)
//   slave  : the environment (PLL, CSR block, video timing generator)
//
//   pll_locked   PLL LOCK output, asynchronous to the 48 MHz clock
//   restart_req  single-cycle pulse forcing a PLL restart
//   pll_rst      PLL RST input
//   video_rst    active-high reset for the video pipeline
//   ready        high only while the PLL is running locked
//   state        0=RESET_PLL, 1=WAIT_LOCK, 2=STABLE, 3=RUN
//   retry_count  saturating count of lock timeouts
//   loss_count   saturating count of loss-of-lock events
//   lost_lock    sticky loss-of-lock flag
// -----------------------------------------------------------------------------
interface vga_pll_sequencer_if #(
  parameter int STAT_W = 8
);
  logic              pll_locked;
  logic              restart_req;
  logic              pll_rst;
  logic              video_rst;
  logic              ready;
  logic [1:0]        state;
  logic [STAT_W-1:0] retry_count;
  logic [STAT_W-1:0] loss_count;
  logic              lost_lock;

  modport master (
    input  pll_locked, restart_req,
    output pll_rst, video_rst, ready, state, retry_count, loss_count, lost_lock
  );

  modport slave (
    output pll_locked, restart_req,
    input  pll_rst, video_rst, ready, state, retry_count, loss_count, lost_lock
  );
endinterface

// File: rtl/vga_pll_sequencer.sv
// -----------------------------------------------------------------------------
// vga_pll_sequencer
//   Brings up the VGA pixel-clock PLL from the 48 MHz input clock: pulses the
//   PLL reset, waits for a lock that stays stable, releases the video reset,
//   and restarts the PLL on a lock timeout, a loss of lock or a software request.
//
//   clkin  : 48 MHz clock, all logic on its rising edge
//   reset  : asynchronous, active-high reset
//   bus    : vga_pll_sequencer_if.master (PLL handshake and status outputs)
// -----------------------------------------------------------------------------
module vga_pll_sequencer #(
  parameter int RST_CYCLES   = 48,
  parameter int LOCK_STABLE  = 4800,
  parameter int LOCK_TIMEOUT = 480000,
  parameter int LOSS_FILTER  = 16,
  parameter int CNT_W        = 20,
  parameter int STAT_W       = 8
) (
  input  logic                   clkin,
  input  logic                   reset,
  vga_pll_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam int FILT_W = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [STAT_W-1:0] retry_q, retry_d;
  logic [STAT_W-1:0] loss_q, loss_d;
  logic              lost_q, lost_d;
  logic              sync1_q, locked_s_q;
  logic              pll_rst_q, video_rst_q, ready_q;

  // Two-flop synchronizer for the asynchronous LOCK signal; only locked_s_q
  // is used by the FSM.
  // NOTE: clocked processes use non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a 2-stage chain.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Next-state logic. The shared counter restarts on every state entry; the
  // loss filter only advances in RUN and is otherwise held at zero.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    filt_d  = '0;
    retry_d = retry_q;
    loss_d  = loss_q;
    lost_d  = lost_q;

    if (bus.restart_req) begin
      // Software restart beats every other event, including a coincident
      // loss of lock or timeout, and never bumps the statistics.
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Lock is tested first so a lock on the timeout cycle wins.
          if (locked_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            if (retry_q != STAT_MAX) retry_d = retry_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A single unlocked cycle sends us back for a fresh timeout window
          // without counting as a retry.
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            if (filt_q == FILT_LAST) begin
              state_d = S_RESET_PLL;
              cnt_d   = '0;
              lost_d  = 1'b1;
              if (loss_q != STAT_MAX) loss_d = loss_q + 1'b1;
            end else begin
              filt_d = filt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State, counters and outputs. Outputs are decoded from the next state so
  // they are registered yet change on the same edge as the state.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lost_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lost_q      <= lost_d;
      pll_rst_q   <= (state_d == S_RESET_PLL);
      video_rst_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.video_rst   = video_rst_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;
  assign bus.retry_count = retry_q;
  assign bus.loss_count  = loss_q;
  assign bus.lost_lock   = lost_q;

endmodule

// File: tb/tb_vga_pll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vga_pll_sequencer
//   Scoreboard bench: each stimulus step pushes the state transitions it must
//   cause (edge number, state, statistics); a negedge monitor pops and compares
//   them whenever the DUT state changes. Direct checks cover reset values and
//   the quiet periods where no transition may occur.
// -----------------------------------------------------------------------------
module tb_vga_pll_sequencer;

  localparam int RST   = 4;
  localparam int STB   = 8;
  localparam int TO    = 32;
  localparam int LF    = 3;
  localparam int SW    = 2;
  // A pll_locked change driven just after edge N is first sampled at edge
  // N+1; the synchronizer delivers it 2 cycles later, so the FSM acts on it
  // at edge N+3.
  localparam int REACT = 3;

  localparam int ST_RESET  = 0;
  localparam int ST_WAIT   = 1;
  localparam int ST_STABLE = 2;
  localparam int ST_RUN    = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  vga_pll_sequencer_if #(.STAT_W(SW)) bus ();

  vga_pll_sequencer #(
    .RST_CYCLES  (RST),
    .LOCK_STABLE (STB),
    .LOCK_TIMEOUT(TO),
    .LOSS_FILTER (LF),
    .CNT_W       (20),
    .STAT_W      (SW)
  ) dut (
    .clkin(clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string tag;
    int    cyc;
    int    st;
    int    retry;
    int    loss;
    int    lost;
  } exp_t;

  exp_t sb_q[$];
  int   e_retry, e_loss, e_lost;

  task automatic check(input string tag, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, want, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v == (1 << SW) - 1) ? v : v + 1;
  endfunction

  function automatic int later(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push(input string tag, input int c, input int st);
    exp_t e;
    e.tag = tag; e.cyc = c; e.st = st;
    e.retry = e_retry; e.loss = e_loss; e.lost = e_lost;
    sb_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending"}, sb_q.size(), 0);
    sb_q.delete();
    step(1);
  endtask

  // Transition monitor
  int   prev_st = ST_RESET;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_st = int'(bus.state);
    end else if (int'(bus.state) != prev_st) begin
      if (sb_q.size() == 0) begin
        check("unexpected_transition", int'(bus.state), prev_st);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, "_edge"},      cyc,             mon_e.cyc);
        check({mon_e.tag, "_state"},     int'(bus.state), mon_e.st);
        check({mon_e.tag, "_retry"},     bus.retry_count, mon_e.retry);
        check({mon_e.tag, "_loss"},      bus.loss_count,  mon_e.loss);
        check({mon_e.tag, "_lost"},      bus.lost_lock,   mon_e.lost);
        check({mon_e.tag, "_pll_rst"},   bus.pll_rst,     int'(mon_e.st == ST_RESET));
        check({mon_e.tag, "_ready"},     bus.ready,       int'(mon_e.st == ST_RUN));
        check({mon_e.tag, "_video_rst"}, bus.video_rst,   int'(mon_e.st != ST_RUN));
      end
      prev_st = int'(bus.state);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     int'(bus.state), ST_RESET);
    check({tag, "_pll_rst"},   bus.pll_rst,     1);
    check({tag, "_video_rst"}, bus.video_rst,   1);
    check({tag, "_ready"},     bus.ready,       0);
    check({tag, "_retry"},     bus.retry_count, 0);
    check({tag, "_loss"},      bus.loss_count,  0);
    check({tag, "_lost"},      bus.lost_lock,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tl, u, rs, st, r, s, d, h, t, wt;
    reset = 1'b1;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;
    e_retry = 0; e_loss = 0; e_lost = 0;
    step(3);
    check_reset_values("por");

    // Power-up: lock rises 10 cycles after release.
    reset = 1'b0; t0 = cyc;
    push("pwr_wait", t0 + RST, ST_WAIT);
    step(10);
    bus.pll_locked = 1'b1; tl = cyc;
    push("pwr_stable", tl + REACT, ST_STABLE);
    push("pwr_run", tl + REACT + STB, ST_RUN);
    wait_drain("pwr", 100);
    check("pwr_ready", bus.ready, 1);
    check("pwr_video_rst", bus.video_rst, 0);

    // Short unlock glitch in RUN is filtered out.
    step(2);
    bus.pll_locked = 1'b0;
    step(LF - 1);
    bus.pll_locked = 1'b1;
    step(8);
    check("glitch_state", int'(bus.state), ST_RUN);
    check("glitch_ready", bus.ready, 1);
    check("glitch_loss", bus.loss_count, 0);

    // Full-length unlock in RUN is a loss of lock.
    bus.pll_locked = 1'b0; u = cyc;
    rs = u + REACT + LF - 1;
    e_loss = sat(e_loss); e_lost = 1;
    push("loss_reset", rs, ST_RESET);
    push("loss_wait", rs + RST, ST_WAIT);
    step(LF);
    bus.pll_locked = 1'b1;
    st = later(rs + RST + 1, cyc + REACT);
    push("loss_stable", st, ST_STABLE);
    push("loss_run", st + STB, ST_RUN);
    step(3);
    check("loss_pll_rst", bus.pll_rst, 1);
    check("loss_ready", bus.ready, 0);
    check("loss_video_rst", bus.video_rst, 1);
    check("loss_count", bus.loss_count, 1);
    check("loss_lost", bus.lost_lock, 1);
    wait_drain("loss", 100);

    // restart_req in RUN, then again in RESET_PLL at count 2.
    check("rq_pre_lost", bus.lost_lock, 1);
    bus.restart_req = 1'b1; r = cyc;
    e_lost = 0;
    push("rq_reset", r + 1, ST_RESET);
    step(1);
    bus.restart_req = 1'b0;
    check("rq_lost_cleared", bus.lost_lock, 0);
    check("rq_loss_kept", bus.loss_count, 1);
    check("rq_retry_kept", bus.retry_count, 0);
    step(2);
    bus.restart_req = 1'b1;
    step(1);
    bus.restart_req = 1'b0;
    push("rq2_wait", r + 4 + RST, ST_WAIT);
    push("rq2_stable", r + 4 + RST + 1, ST_STABLE);
    push("rq2_run", r + 4 + RST + 1 + STB, ST_RUN);
    wait_drain("rq2", 100);

    // One-cycle lock drop in STABLE at count 5.
    bus.restart_req = 1'b1; r = cyc;
    push("drop_reset", r + 1, ST_RESET);
    step(1);
    bus.restart_req = 1'b0;
    s = r + 1 + RST + 1;
    push("drop_wait0", r + 1 + RST, ST_WAIT);
    push("drop_stable0", s, ST_STABLE);
    step(s + 3 - cyc);
    bus.pll_locked = 1'b0; d = cyc;
    push("drop_wait", d + REACT, ST_WAIT);
    step(1);
    bus.pll_locked = 1'b1;
    push("drop_stable", d + REACT + 1, ST_STABLE);
    push("drop_run", d + REACT + 1 + STB, ST_RUN);
    wait_drain("drop", 100);
    check("drop_retry_kept", bus.retry_count, 0);

    // Lock held low: repeated timeouts, retry_count saturates.
    bus.pll_locked = 1'b0; h = cyc;
    t = h + REACT + LF - 1;
    e_loss = sat(e_loss); e_lost = 1;
    push("hold_loss", t, ST_RESET);
    for (int i = 0; i < 4; i++) begin
      push("hold_wait", t + RST, ST_WAIT);
      t = t + RST + TO;
      e_retry = sat(e_retry);
      push("hold_retry", t, ST_RESET);
    end
    wait_drain("hold", 400);
    check("hold_retry_sat", bus.retry_count, 3);
    check("hold_loss_count", bus.loss_count, 2);

    // Relock and go to STABLE.
    wt = t + RST;
    push("relock_wait", wt, ST_WAIT);
    bus.pll_locked = 1'b1;
    push("relock_stable", later(wt + 1, cyc + REACT), ST_STABLE);
    wait_drain("relock", 60);

    // Asynchronous reset between edges in STABLE.
    step(2);
    check("pre_areset_state", int'(bus.state), ST_STABLE);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("areset");
    e_retry = 0; e_loss = 0; e_lost = 0;
    step(2);
    reset = 1'b0; t0 = cyc;
    push("rerun_wait", t0 + RST, ST_WAIT);
    push("rerun_stable", t0 + RST + 1, ST_STABLE);
    push("rerun_run", t0 + RST + 1 + STB, ST_RUN);
    wait_drain("rerun", 100);
    check("rerun_ready", bus.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
